sbox_sched: RTL and testbench

Shared S-box scheduler: time-multiplexes one 32-bit `subword` S-box slice (4 byte S-boxes) between the cipher round datapath and the key-expansion unit. A full 128-bit SubBytes runs as four single-word passes; a key-expansion SubWord runs as one pass. Each requester sees a valid/ready request/response pair. Replaces the 16-S-box `subbytes` array in area-optimised builds.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/subword.sv | 23 ++
 rtl/sbox_sched.sv | 128 ++++++++++++
 tb/tb_sbox_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: scheduler state encoding, word type and the byte S-box table.
package aes_pkg;

    localparam int unsigned NWORDS  = 4;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned CNT_W   = $clog2(NWORDS);
    localparam int unsigned STATE_W = NWORDS * WORD_W;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        ST_RUN,
        KW_RUN,
        ST_DONE,
        KW_DONE
    } sched_state_t;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte x sits at bits [2047-8x -: 8]; 2047-8x == {~x, 3'b111}.
    function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b111} -: 8];
    endfunction

endpackage

// File: rtl/subword.sv
// Combinational 32-bit SubWord: four byte S-box ROMs side by side.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    assign y = sbox_lookup(a);
endmodule

module subword
    import aes_pkg::*;
(
    input  word_t a,
    output word_t y
);
    for (genvar i = 0; i < 4; i++) begin : g_byte
        sbox u_sbox (
            .a (a[8*i +: 8]),
            .y (y[8*i +: 8])
        );
    end
endmodule

// File: rtl/sbox_sched.sv
// Time-multiplexes one SubWord slice between the round datapath (4 passes) and key expansion (1 pass).
module sbox_sched
    import aes_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               st_req_valid,
    output logic               st_req_ready,
    input  logic [STATE_W-1:0] st_in,
    output logic               st_rsp_valid,
    input  logic               st_rsp_ready,
    output logic [STATE_W-1:0] st_out,
    input  logic               kw_req_valid,
    output logic               kw_req_ready,
    input  word_t              kw_in,
    output logic               kw_rsp_valid,
    input  logic               kw_rsp_ready,
    output word_t              kw_out
);

    sched_state_t state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             last_st, last_st_d;
    logic             grant_kw;
    word_t            sb_in, sb_out;
    word_t            kw_out_d;

    // Word 0 is the most significant word, so word n lives at index NWORDS-1-n == ~n.
    logic [NWORDS-1:0][WORD_W-1:0] opnd, opnd_d;
    logic [NWORDS-1:0][WORD_W-1:0] st_w, st_w_d;

    subword u_subword (
        .a (sb_in),
        .y (sb_out)
    );

    assign st_out       = st_w;
    assign st_rsp_valid = (state == ST_DONE);
    assign kw_rsp_valid = (state == KW_DONE);

    // Arbitration between the two requesters; last_st alternates ties in round-robin mode.
    always_comb begin
        grant_kw = 1'b0;
        unique case ({st_req_valid, kw_req_valid})
            2'b01:   grant_kw = 1'b1;
            2'b10:   grant_kw = 1'b0;
            2'b11:   grant_kw = FIXED_PRIO ? 1'b1 : last_st;
            default: grant_kw = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            last_st <= 1'b1;
            opnd    <= '0;
            st_w    <= '0;
            kw_out  <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            last_st <= last_st_d;
            opnd    <= opnd_d;
            st_w    <= st_w_d;
            kw_out  <= kw_out_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        last_st_d    = last_st;
        opnd_d       = opnd;
        st_w_d       = st_w;
        kw_out_d     = kw_out;
        sb_in        = '0;
        st_req_ready = 1'b0;
        kw_req_ready = 1'b0;

        unique case (state)
            IDLE: begin
                if (!reset && (st_req_valid || kw_req_valid)) begin
                    cnt_d = '0;
                    if (grant_kw) begin
                        kw_req_ready = 1'b1;
                        opnd_d       = '0;
                        opnd_d[0]    = kw_in;
                        last_st_d    = 1'b0;
                        state_d      = KW_RUN;
                    end else begin
                        st_req_ready = 1'b1;
                        opnd_d       = st_in;
                        last_st_d    = 1'b1;
                        state_d      = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                sb_in         = opnd[~cnt];
                st_w_d[~cnt]  = sb_out;
                cnt_d         = cnt + CNT_W'(1);
                if (cnt == CNT_W'(NWORDS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            KW_RUN: begin
                sb_in    = opnd[0];
                kw_out_d = sb_out;
                state_d  = KW_DONE;
            end
            ST_DONE: begin
                if (st_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            KW_DONE: begin
                if (kw_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sbox_sched.sv
// Directed scoreboard bench for sbox_sched: round-robin instance plus a fixed-priority instance.
module tb_sbox_sched;
    logic         clk = 1'b0;
    logic         reset;

    logic         st_req_valid, st_req_ready, st_rsp_valid, st_rsp_ready;
    logic [127:0] st_in, st_out;
    logic         kw_req_valid, kw_req_ready, kw_rsp_valid, kw_rsp_ready;
    logic [31:0]  kw_in, kw_out;

    logic         f_st_req_valid, f_st_req_ready, f_st_rsp_valid, f_st_rsp_ready;
    logic [127:0] f_st_in, f_st_out;
    logic         f_kw_req_valid, f_kw_req_ready, f_kw_rsp_valid, f_kw_rsp_ready;
    logic [31:0]  f_kw_in, f_kw_out;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    int acc;
    logic [127:0] sb_st[$], sb_kw[$], sb_fst[$], sb_fkw[$];
    logic [127:0] dropped;

    localparam logic [127:0] ST_V1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ST_E1 = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [31:0]  KW_V1 = 32'hcf4f3c09;
    localparam logic [31:0]  KW_E1 = 32'h8a84eb01;

    sbox_sched #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_in(st_in),
        .st_rsp_valid(st_rsp_valid), .st_rsp_ready(st_rsp_ready), .st_out(st_out),
        .kw_req_valid(kw_req_valid), .kw_req_ready(kw_req_ready), .kw_in(kw_in),
        .kw_rsp_valid(kw_rsp_valid), .kw_rsp_ready(kw_rsp_ready), .kw_out(kw_out)
    );

    sbox_sched #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(reset),
        .st_req_valid(f_st_req_valid), .st_req_ready(f_st_req_ready), .st_in(f_st_in),
        .st_rsp_valid(f_st_rsp_valid), .st_rsp_ready(f_st_rsp_ready), .st_out(f_st_out),
        .kw_req_valid(f_kw_req_valid), .kw_req_ready(f_kw_req_ready), .kw_in(f_kw_in),
        .kw_rsp_valid(f_kw_rsp_valid), .kw_rsp_ready(f_kw_rsp_ready), .kw_out(f_kw_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return st_req_ready;
            1:       return kw_req_ready;
            2:       return st_rsp_valid;
            3:       return kw_rsp_valid;
            4:       return f_st_req_ready;
            5:       return f_kw_req_ready;
            6:       return f_st_rsp_valid;
            default: return f_kw_rsp_valid;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        int n = 0;
        #1;
        while (!probe(sel) && n < 40) begin
            step();
            n++;
        end
        if (!probe(sel)) chk({tag, "_timeout"}, 128'd0, 128'd1);
    endtask

    // Response scoreboards: compare on every completed handshake.
    always @(negedge clk) begin
        if (!reset && st_rsp_valid && st_rsp_ready) begin
            if (sb_st.size() == 0) chk("st_unexpected_rsp", 128'd1, 128'd0);
            else chk("st_out", st_out, sb_st.pop_front());
        end
        if (!reset && kw_rsp_valid && kw_rsp_ready) begin
            if (sb_kw.size() == 0) chk("kw_unexpected_rsp", 128'd1, 128'd0);
            else chk("kw_out", {96'd0, kw_out}, sb_kw.pop_front());
        end
        if (!reset && f_st_rsp_valid && f_st_rsp_ready) begin
            if (sb_fst.size() == 0) chk("fp_st_unexpected_rsp", 128'd1, 128'd0);
            else chk("fp_st_out", f_st_out, sb_fst.pop_front());
        end
        if (!reset && f_kw_rsp_valid && f_kw_rsp_ready) begin
            if (sb_fkw.size() == 0) chk("fp_kw_unexpected_rsp", 128'd1, 128'd0);
            else chk("fp_kw_out", {96'd0, f_kw_out}, sb_fkw.pop_front());
        end
    end

    initial begin
        logic [31:0] kv [3];
        logic [31:0] ke [3];
        kv = '{32'h00000000, KW_V1, 32'hffffffff};
        ke = '{32'h63636363, KW_E1, 32'h16161616};

        reset = 1'b1;
        st_req_valid = 0; st_rsp_ready = 0; st_in = '0;
        kw_req_valid = 0; kw_rsp_ready = 0; kw_in = '0;
        f_st_req_valid = 0; f_st_rsp_ready = 0; f_st_in = '0;
        f_kw_req_valid = 0; f_kw_rsp_ready = 0; f_kw_in = '0;
        step(2);

        // Reset values, with requests pending
        st_req_valid = 1; kw_req_valid = 1; #1;
        chk("rst_st_req_ready", 128'(st_req_ready), 128'd0);
        chk("rst_kw_req_ready", 128'(kw_req_ready), 128'd0);
        chk("rst_st_rsp_valid", 128'(st_rsp_valid), 128'd0);
        chk("rst_kw_rsp_valid", 128'(kw_rsp_valid), 128'd0);
        chk("rst_st_out", st_out, 128'd0);
        chk("rst_kw_out", {96'd0, kw_out}, 128'd0);
        step();
        reset = 0; st_req_valid = 0; kw_req_valid = 0;
        step();

        // State only
        st_in = ST_V1; st_req_valid = 1;
        wait_for(0, "st_only_acc");
        chk("st_only_kw_ready", 128'(kw_req_ready), 128'd0);
        sb_st.push_back(ST_E1); acc = cyc;
        step(); st_req_valid = 0;
        wait_for(2, "st_only_rsp");
        chk("st_latency", 128'(cyc - acc), 128'd5);
        st_rsp_ready = 1; step(); st_rsp_ready = 0;
        chk("st_valid_drop", 128'(st_rsp_valid), 128'd0);
        chk("st_out_retained", st_out, ST_E1);

        // Key only, with response held off for 4 cycles
        kw_in = KW_V1; kw_req_valid = 1;
        wait_for(1, "kw_only_acc");
        sb_kw.push_back({96'd0, KW_E1}); acc = cyc;
        step(); kw_req_valid = 0;
        wait_for(3, "kw_only_rsp");
        chk("kw_latency", 128'(cyc - acc), 128'd2);
        for (int i = 0; i < 4; i++) begin
            chk("kw_hold_valid", 128'(kw_rsp_valid), 128'd1);
            chk("kw_hold_data", {96'd0, kw_out}, {96'd0, KW_E1});
            step();
        end
        kw_rsp_ready = 1; step();
        chk("kw_valid_drop", 128'(kw_rsp_valid), 128'd0);

        // Tie after reset, round-robin
        reset = 1; step(); reset = 0;
        st_rsp_ready = 1; kw_rsp_ready = 1;
        st_in = ST_V1; kw_in = KW_V1; st_req_valid = 1; kw_req_valid = 1; #1;
        chk("tie1_kw_ready", 128'(kw_req_ready), 128'd1);
        chk("tie1_st_ready", 128'(st_req_ready), 128'd0);
        sb_kw.push_back({96'd0, KW_E1}); acc = cyc;
        step(); kw_req_valid = 0;
        wait_for(0, "tie1_st_acc");
        chk("tie1_st_gap", 128'(cyc - acc), 128'd3);
        sb_st.push_back(ST_E1); acc = cyc;
        step(); kw_req_valid = 1;
        wait_for(1, "tie2_kw_acc");
        chk("tie2_st_ready", 128'(st_req_ready), 128'd0);
        chk("tie2_kw_gap", 128'(cyc - acc), 128'd6);
        sb_kw.push_back({96'd0, KW_E1}); acc = cyc;
        step(); kw_req_valid = 0;
        wait_for(0, "tie2_st_acc");
        chk("tie2_st_gap", 128'(cyc - acc), 128'd3);
        sb_st.push_back(ST_E1);
        step(); st_req_valid = 0;
        step(6);
        chk("tie_drain", 128'(sb_st.size() + sb_kw.size()), 128'd0);

        // Reset during ST_RUN at cnt==2 discards the partial result
        st_rsp_ready = 0; st_in = ST_V1; st_req_valid = 1;
        wait_for(0, "abort_acc");
        sb_st.push_back(ST_E1);
        step(); st_req_valid = 0;
        step(2);
        reset = 1; step(); reset = 0;
        dropped = sb_st.pop_back();
        chk("abort_st_rsp_valid", 128'(st_rsp_valid), 128'd0);
        chk("abort_st_out", st_out, 128'd0);
        st_in = '0; st_req_valid = 1; #1;
        chk("abort_idle_ready", 128'(st_req_ready), 128'd1);
        sb_st.push_back({16{8'h63}});
        step(); st_req_valid = 0; st_rsp_ready = 1;
        wait_for(2, "abort_next_rsp");
        step(); st_rsp_ready = 0;

        // Back-pressure on the state response blocks the key requester
        st_in = {16{8'hff}}; st_req_valid = 1;
        wait_for(0, "bp_st_acc");
        sb_st.push_back({16{8'h16}});
        step(); st_req_valid = 0; kw_in = KW_V1; kw_req_valid = 1; #1;
        for (int i = 0; i < 14; i++) begin
            chk("bp_kw_ready_low", 128'(kw_req_ready), 128'd0);
            step();
        end
        chk("bp_st_rsp_held", 128'(st_rsp_valid), 128'd1);
        st_rsp_ready = 1; #1;
        chk("bp_kw_ready_done", 128'(kw_req_ready), 128'd0);
        step(); st_rsp_ready = 0;
        chk("bp_kw_ready_idle", 128'(kw_req_ready), 128'd1);
        sb_kw.push_back({96'd0, KW_E1});
        step(); kw_req_valid = 0;
        wait_for(3, "bp_kw_rsp");
        step();

        // Fixed priority: key wins every tie
        f_st_rsp_ready = 1; f_kw_rsp_ready = 1;
        f_st_in = ST_V1; f_st_req_valid = 1; f_kw_req_valid = 1;
        for (int i = 0; i < 3; i++) begin
            f_kw_in = kv[i];
            wait_for(5, "fp_kw_acc");
            chk("fp_tie_st_ready", 128'(f_st_req_ready), 128'd0);
            sb_fkw.push_back({96'd0, ke[i]});
            step();
        end
        f_kw_req_valid = 0;
        wait_for(4, "fp_st_acc");
        sb_fst.push_back(ST_E1);
        step(); f_st_req_valid = 0;
        step(8);

        chk("sb_st_empty", 128'(sb_st.size()), 128'd0);
        chk("sb_kw_empty", 128'(sb_kw.size()), 128'd0);
        chk("sb_fp_st_empty", 128'(sb_fst.size()), 128'd0);
        chk("sb_fp_kw_empty", 128'(sb_fkw.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
